axis_tx_pkt_fifo: RTL

//  Store-and-forward packet FIFO between the RX->TX bridge and the MAC TX port. The bridge

---
 rtl/axis2tap_pkg.sv | 21 ++
 rtl/axis_pkt_ram.sv | 27 ++
 rtl/axis_tx_pkt_fifo.sv | 118 +++++++++++
 3 files changed

// File: rtl/axis2tap_pkg.sv
// Shared types for the AXIS TX packet FIFO: beat layout and write-side FSM encoding.
package axis2tap_pkg;

  localparam int AXIS_DATA_W = 64;
  localparam int AXIS_KEEP_W = 8;

  typedef struct packed {
    logic                   last;
    logic [AXIS_KEEP_W-1:0] keep;
    logic [AXIS_DATA_W-1:0] data;
  } axis_beat_t;

  localparam int BEAT_W = $bits(axis_beat_t);

  typedef enum logic [1:0] {
    WR_IDLE  = 2'd0,
    WR_WRITE = 2'd1,
    WR_DROP  = 2'd2
  } wr_state_e;

endpackage

// File: rtl/axis_pkt_ram.sv
// Simple dual-port beat storage: synchronous write, asynchronous read, contents never reset.
module axis_pkt_ram
  import axis2tap_pkg::*;
#(
  parameter int DEPTH = 512,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  axis_beat_t      wdata,
  input  logic [AW-1:0]   raddr,
  output axis_beat_t      rdata
);

  axis_beat_t mem [DEPTH];

  // write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axis_tx_pkt_fifo.sv
// Store-and-forward packet FIFO: only complete, error-free packets become visible to the MAC;
// overflowing or tuser-flagged packets are rolled back to the last commit point and counted.
module axis_tx_pkt_fifo
  import axis2tap_pkg::*;
#(
  parameter int DEPTH = 512,
  parameter int CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_axis_tvalid,
  input  logic [AXIS_DATA_W-1:0] s_axis_tdata,
  input  logic [AXIS_KEEP_W-1:0] s_axis_tkeep,
  input  logic                   s_axis_tlast,
  input  logic                   s_axis_tuser,
  input  logic                   m_axis_tx_tready,
  output logic                   m_axis_tx_tvalid,
  output logic [AXIS_DATA_W-1:0] m_axis_tx_tdata,
  output logic [AXIS_KEEP_W-1:0] m_axis_tx_tkeep,
  output logic                   m_axis_tx_tlast,
  output logic                   m_axis_tx_tuser,
  output logic [CNT_W-1:0]       pkt_fwd_cnt,
  output logic [CNT_W-1:0]       pkt_drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]      PTR_INC   = (AW+1)'(1);
  localparam logic [AW:0]      PTR_DEPTH = (AW+1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_INC   = CNT_W'(1);

  logic [AW:0] wr_ptr;
  logic [AW:0] commit_ptr;
  logic [AW:0] rd_ptr;
  wr_state_e   state;
  axis_beat_t  in_beat;
  axis_beat_t  ram_rdata;
  axis_beat_t  out_beat;
  logic        full;
  logic        store;
  logic        load;

  assign in_beat = '{last: s_axis_tlast, keep: s_axis_tkeep, data: s_axis_tdata};

  // Registered rd_ptr: a pop in this cycle does not free space for this cycle's write.
  assign full  = (wr_ptr - rd_ptr) == PTR_DEPTH;
  assign store = s_axis_tvalid && (state != WR_DROP) && !full && !(s_axis_tlast && s_axis_tuser);
  assign load  = (rd_ptr != commit_ptr) && (!m_axis_tx_tvalid || m_axis_tx_tready);

  axis_pkt_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (store),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (in_beat),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (ram_rdata)
  );

  // write side: speculative pointer, commit point, drop FSM and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      commit_ptr   <= '0;
      state        <= WR_IDLE;
      pkt_fwd_cnt  <= '0;
      pkt_drop_cnt <= '0;
    end else if (s_axis_tvalid) begin
      case (state)
        WR_DROP: begin
          if (s_axis_tlast) begin
            state        <= WR_IDLE;
            pkt_drop_cnt <= pkt_drop_cnt + CNT_INC;
          end
        end
        WR_IDLE, WR_WRITE: begin
          if (full || (s_axis_tlast && s_axis_tuser)) begin
            wr_ptr <= commit_ptr;
            if (s_axis_tlast) begin
              state        <= WR_IDLE;
              pkt_drop_cnt <= pkt_drop_cnt + CNT_INC;
            end else begin
              state <= WR_DROP;
            end
          end else if (s_axis_tlast) begin
            wr_ptr      <= wr_ptr + PTR_INC;
            commit_ptr  <= wr_ptr + PTR_INC;
            pkt_fwd_cnt <= pkt_fwd_cnt + CNT_INC;
            state       <= WR_IDLE;
          end else begin
            wr_ptr <= wr_ptr + PTR_INC;
            state  <= WR_WRITE;
          end
        end
        default: state <= WR_IDLE;
      endcase
    end
  end

  // read side: single output register, tvalid doubles as its occupancy flag
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr           <= '0;
      out_beat         <= '0;
      m_axis_tx_tvalid <= 1'b0;
    end else if (load) begin
      rd_ptr           <= rd_ptr + PTR_INC;
      out_beat         <= ram_rdata;
      m_axis_tx_tvalid <= 1'b1;
    end else if (m_axis_tx_tready) begin
      m_axis_tx_tvalid <= 1'b0;
    end
  end

  assign m_axis_tx_tdata = out_beat.data;
  assign m_axis_tx_tkeep = out_beat.keep;
  assign m_axis_tx_tlast = out_beat.last;
  assign m_axis_tx_tuser = 1'b0;

endmodule
